adder_chunked: RTL and testbench
================================

// Module: adder_chunked
// PURPOSE
//   Multi-cycle N-bit add/subtract unit. Processes W bits per clock, LSB chunk first,
//   through one W-bit adder slice, trading latency for area against the single-cycle
//   adder_n. Used wherever wide adds need not finish in one cycle; start/ready/done handshake.
// PARAMETERS
//   N  32  operand/result width in bits
//   W   8  chunk width per cycle; N % W == 0 required (elaboration error otherwise); K = N/W
// PORTS
//   clk       in   1  clock, rising-edge
//   rst       in   1  asynchronous reset, active-high
//   start     in   1  request; accepted only when ready=1
//   a         in   N  operand A, sampled on the accepting edge
//   b         in   N  operand B, sampled on the accepting edge
//   c_in      in   1  carry-in, sampled on the accepting edge (ignored when sub=1)
//   sub       in   1  1: compute a - b; 0: a + b + c_in; sampled on the accepting edge
//   ready     out  1  1 when a new start will be accepted
//   done      out  1  one-cycle pulse: result registers just updated
//   sum       out  N  result, held until the next accepted start completes
//   c_out     out  1  carry out of bit N-1 (for sub: 1 = no borrow)
//   overflow  out  1  signed overflow: carry into bit N-1 XOR carry out of bit N-1
// BEHAVIOUR
//   Reset (async, any time incl. mid-operation): state=IDLE, chunk counter=0, operand and
//     partial-sum registers=0, carry=0; outputs ready=1, done=0, sum=0, c_out=0, overflow=0.
//   FSM: IDLE -> BUSY on start&ready; BUSY stays K cycles; BUSY -> DONE after chunk K-1;
//     DONE -> BUSY if start, else IDLE. ready=1 in IDLE and DONE, 0 in BUSY. done=1 only in DONE.
//   Accept (edge E0): latch a; latch b, or ~b when sub=1; carry <= sub ? 1 : c_in; counter <= 0.
//   Edges E1..EK: chunk i = counter: {c,s} = a[i*W +: W] + bop[i*W +: W] + carry;
//     s written into partial sum at bits i*W +: W; carry <= c; counter increments.
//     On EK also capture carry into bit N-1 for overflow.
//   Edge EK: sum, c_out, overflow updated together; DONE occupies cycle EK..EK+1.
//   Latency: start accepted at E0 -> done high in the cycle after EK (K+1 edges after E0).
//   Outputs sum/c_out/overflow change only on EK; stable during BUSY (previous result held).
//   Arithmetic modulo 2^N; c_out/overflow as defined above; sub ignores c_in entirely.
//   start while BUSY: ignored, no effect on operation in flight.
//   start in DONE: accepted (back-to-back); next done exactly K+1 cycles later.
//   K=1 (W=N): single BUSY cycle, latency 2 edges. W=1: bit-serial, K=N.
//   Counter width $clog2(K), minimum 1 bit.
// TESTING
//   N=32,W=8: a=0,b=0,c_in=0 -> sum=0,c_out=0,ovf=0, done exactly 5 edges after accept.
//   a=32'hFFFF_FFFF,b=1,c_in=0 -> sum=0,c_out=1,ovf=0; a=32'h7FFF_FFFF,b=1 -> sum=32'h8000_0000,ovf=1.
//   sub=1,a=5,b=7,c_in=1 -> sum=32'hFFFF_FFFE,c_out=0,ovf=0; a=7,b=5 -> sum=2,c_out=1.
//   start pulsed during BUSY with other operands -> ignored; start in DONE -> second result correct.
//   rst asserted mid-BUSY -> all outputs 0, ready=1 immediately (async); fresh op then correct.
//   Param sweep (N,W)=(32,8),(32,32),(16,1),(12,4): 1000 random ops vs {c,sum}=a+b+c_in model.

Source files
------------

// File: rtl/adder_chunked.sv
// adder_chunked: multi-cycle N-bit add/subtract, W bits per clock.
// One W-bit adder slice walks the operands LSB chunk first.
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-high reset
//   start    in   request, accepted only while ready=1
//   a, b     in   N-bit operands, sampled on the accepting edge
//   c_in     in   carry-in (ignored when sub=1)
//   sub      in   1: a - b, 0: a + b + c_in
//   ready    out  a new start will be accepted
//   done     out  one-cycle pulse, result registers just updated
//   sum      out  N-bit result, held until the next op completes
//   c_out    out  carry out of bit N-1 (sub: 1 = no borrow)
//   overflow out  signed overflow of the result
module adder_chunked #(
   parameter int N = 32,
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         c_in,
   input  logic         sub,
   output logic         ready,
   output logic         done,
   output logic [N-1:0] sum,
   output logic         c_out,
   output logic         overflow
);

   localparam int K  = N / W;
   localparam int CW = (K > 1) ? $clog2(K) : 1;

   if ((W < 1) || (N % W != 0)) begin : g_bad_width
      $error("adder_chunked: N must be a multiple of W");
   end

   typedef enum logic [1:0] {
      S_IDLE,
      S_BUSY,
      S_DONE
   } state_t;

   state_t          r_state;
   logic [CW-1:0]   r_cnt;
   logic [N-1:0]    r_a;
   logic [N-1:0]    r_b;
   logic [N-1:0]    r_acc;
   logic            r_carry;

   logic [W-1:0]    w_a_chk;
   logic [W-1:0]    w_b_chk;
   logic [W-1:0]    w_s;
   logic            w_c;
   logic            w_ovf;
   logic            w_last;
   logic [N-1:0]    w_acc_nxt;

   always_comb begin
      w_a_chk = r_a[int'(r_cnt) * W +: W];
      w_b_chk = r_b[int'(r_cnt) * W +: W];
      {w_c, w_s} = {1'b0, w_a_chk}
                 + {1'b0, w_b_chk}
                 + {{W{1'b0}}, r_carry};
      // carry into the top bit is recovered from the
      // top-bit inputs and sum, so no second adder
      w_ovf = w_a_chk[W-1] ^ w_b_chk[W-1]
            ^ w_s[W-1] ^ w_c;
      w_last = (r_cnt == CW'(K - 1));
      w_acc_nxt = r_acc;
      w_acc_nxt[int'(r_cnt) * W +: W] = w_s;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_a      <= '0;
         r_b      <= '0;
         r_acc    <= '0;
         r_carry  <= 1'b0;
         ready    <= 1'b1;
         done     <= 1'b0;
         sum      <= '0;
         c_out    <= 1'b0;
         overflow <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (r_state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  r_a     <= a;
                  // subtract as a + ~b + 1
                  r_b     <= sub ? ~b : b;
                  r_carry <= sub ? 1'b1 : c_in;
                  r_cnt   <= '0;
                  r_state <= S_BUSY;
                  ready   <= 1'b0;
               end else begin
                  r_state <= S_IDLE;
                  ready   <= 1'b1;
               end
            end
            S_BUSY: begin
               r_acc   <= w_acc_nxt;
               r_carry <= w_c;
               if (w_last) begin
                  r_cnt    <= '0;
                  sum      <= w_acc_nxt;
                  c_out    <= w_c;
                  overflow <= w_ovf;
                  r_state  <= S_DONE;
                  ready    <= 1'b1;
                  done     <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: begin
               r_state <= S_IDLE;
               ready   <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_adder_chunked.sv
// tb_adder_chunked: directed and random checks of adder_chunked
// for (N,W) = (32,8), (32,32), (16,1), (12,4).
module tb_adder_chunked;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  start;
   logic [31:0] a;
   logic [31:0] b;
   logic        c_in;
   logic        sub;

   logic [3:0]  rdy;
   logic [3:0]  dn;
   logic [3:0]  co;
   logic [3:0]  ov;
   logic [31:0] s0;
   logic [31:0] s1;
   logic [15:0] s2;
   logic [11:0] s3;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   adder_chunked #(.N(32), .W(8)) u0 (
      .clk(clk), .rst(rst), .start(start[0]),
      .a(a), .b(b), .c_in(c_in), .sub(sub),
      .ready(rdy[0]), .done(dn[0]), .sum(s0),
      .c_out(co[0]), .overflow(ov[0])
   );

   adder_chunked #(.N(32), .W(32)) u1 (
      .clk(clk), .rst(rst), .start(start[1]),
      .a(a), .b(b), .c_in(c_in), .sub(sub),
      .ready(rdy[1]), .done(dn[1]), .sum(s1),
      .c_out(co[1]), .overflow(ov[1])
   );

   adder_chunked #(.N(16), .W(1)) u2 (
      .clk(clk), .rst(rst), .start(start[2]),
      .a(a[15:0]), .b(b[15:0]), .c_in(c_in), .sub(sub),
      .ready(rdy[2]), .done(dn[2]), .sum(s2),
      .c_out(co[2]), .overflow(ov[2])
   );

   adder_chunked #(.N(12), .W(4)) u3 (
      .clk(clk), .rst(rst), .start(start[3]),
      .a(a[11:0]), .b(b[11:0]), .c_in(c_in), .sub(sub),
      .ready(rdy[3]), .done(dn[3]), .sum(s3),
      .c_out(co[3]), .overflow(ov[3])
   );

   task automatic check(input string tag,
                        input logic [63:0] got,
                        input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic int width_of(input int sel);
      case (sel)
         0: return 32;
         1: return 32;
         2: return 16;
         default: return 12;
      endcase
   endfunction

   function automatic int lat_of(input int sel);
      case (sel)
         0: return 5;
         1: return 2;
         2: return 17;
         default: return 4;
      endcase
   endfunction

   function automatic logic [31:0] out_sum(input int sel);
      case (sel)
         0: return s0;
         1: return s1;
         2: return {16'b0, s2};
         default: return {20'b0, s3};
      endcase
   endfunction

   function automatic logic [33:0] model(input int n,
                                         input logic [31:0] ai,
                                         input logic [31:0] bi,
                                         input logic ci,
                                         input logic si);
      logic [63:0] m, x, y, t;
      logic c, v;
      m = (64'd1 << n) - 64'd1;
      x = {32'b0, ai} & m;
      y = (si ? {32'b0, ~bi} : {32'b0, bi}) & m;
      t = x + y + {63'b0, (si ? 1'b1 : ci)};
      c = t[n];
      v = (x[n-1] == y[n-1]) && (t[n-1] != x[n-1]);
      return {v, c, 32'(t & m)};
   endfunction

   task automatic run_op(input int sel,
                         input logic [31:0] ai,
                         input logic [31:0] bi,
                         input logic ci,
                         input logic si,
                         output logic [31:0] rs,
                         output logic rc,
                         output logic rv,
                         output int lat);
      int t;
      t = 0;
      @(negedge clk);
      while (!rdy[sel] && t < 100) begin
         @(negedge clk);
         t++;
      end
      check("ready_wait", rdy[sel], 1);
      a = ai;
      b = bi;
      c_in = ci;
      sub = si;
      start[sel] = 1'b1;
      @(posedge clk);
      #1;
      start[sel] = 1'b0;
      lat = 1;
      while (!dn[sel] && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
      rs = out_sum(sel);
      rc = co[sel];
      rv = ov[sel];
   endtask

   task automatic dir_op(input string tag, input int sel,
                         input logic [31:0] ai,
                         input logic [31:0] bi,
                         input logic ci, input logic si,
                         input logic [31:0] es,
                         input logic ec, input logic ev);
      logic [31:0] rs;
      logic rc, rv;
      int lat;
      run_op(sel, ai, bi, ci, si, rs, rc, rv, lat);
      check({tag, "_sum"}, rs, es);
      check({tag, "_cout"}, rc, ec);
      check({tag, "_ovf"}, rv, ev);
      check({tag, "_lat"}, lat, lat_of(sel));
   endtask

   task automatic rand_op(input int sel);
      logic [31:0] ai, bi, rs;
      logic ci, si, rc, rv;
      logic [33:0] e;
      int lat;
      ai = $urandom;
      bi = $urandom;
      ci = 1'($urandom_range(0, 1));
      si = 1'($urandom_range(0, 1));
      e = model(width_of(sel), ai, bi, ci, si);
      run_op(sel, ai, bi, ci, si, rs, rc, rv, lat);
      check("rnd_sum", rs, e[31:0]);
      check("rnd_cout", rc, e[32]);
      check("rnd_ovf", rv, e[33]);
      check("rnd_lat", lat, lat_of(sel));
   endtask

   initial begin
      int lat;
      rst = 1'b1;
      start = '0;
      a = '0;
      b = '0;
      c_in = 1'b0;
      sub = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", rdy, 4'hF);
      check("rst_done", dn, 4'h0);
      check("rst_sum", s0, 0);
      check("rst_cout", co, 4'h0);
      check("rst_ovf", ov, 4'h0);
      @(negedge clk);
      rst = 1'b0;

      dir_op("zero", 0, 0, 0, 0, 0, 0, 0, 0);
      dir_op("wrap", 0, 32'hFFFF_FFFF, 1, 0, 0, 0, 1, 0);
      dir_op("sovf", 0, 32'h7FFF_FFFF, 1, 0, 0,
             32'h8000_0000, 0, 1);
      dir_op("sub57", 0, 5, 7, 1, 1, 32'hFFFF_FFFE, 0, 0);
      dir_op("sub75", 0, 7, 5, 0, 1, 2, 1, 0);
      dir_op("cin", 0, 1, 2, 1, 0, 4, 0, 0);
      dir_op("negneg", 0, 32'h8000_0000, 32'h8000_0000,
             0, 0, 0, 1, 1);
      dir_op("subovf", 0, 32'h8000_0000, 1, 0, 1,
             32'h7FFF_FFFF, 1, 1);
      dir_op("chunkc", 0, 32'h0000_00FF, 1, 0, 0,
             32'h0000_0100, 0, 0);

      // start pulsed while busy must be ignored
      @(negedge clk);
      a = 10;
      b = 20;
      c_in = 1'b0;
      sub = 1'b0;
      start[0] = 1'b1;
      @(posedge clk);
      #1;
      start[0] = 1'b0;
      @(negedge clk);
      check("busy_ready", rdy[0], 0);
      check("busy_hold", s0, 32'h100);
      a = 999;
      b = 1;
      sub = 1'b1;
      start[0] = 1'b1;
      @(posedge clk);
      #1;
      start[0] = 1'b0;
      lat = 2;
      while (!dn[0] && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check("ign_lat", lat, 5);
      check("ign_sum", s0, 30);
      @(posedge clk);
      #1;
      check("ign_norestart", dn[0], 0);
      check("ign_idle_ready", rdy[0], 1);

      // back-to-back: second start lands in DONE
      dir_op("b2b1", 0, 100, 23, 0, 0, 123, 0, 0);
      check("b2b_in_done", dn[0], 1);
      dir_op("b2b2", 0, 32'hC000_0000, 32'hC000_0000,
             0, 0, 32'h8000_0000, 1, 0);

      // async reset in the middle of an operation
      @(negedge clk);
      a = 32'h1111_1111;
      b = 32'h2222_2222;
      sub = 1'b0;
      start[0] = 1'b1;
      @(posedge clk);
      #1;
      start[0] = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("mrst_ready", rdy[0], 1);
      check("mrst_done", dn[0], 0);
      check("mrst_sum", s0, 0);
      check("mrst_cout", co[0], 0);
      check("mrst_ovf", ov[0], 0);
      @(negedge clk);
      rst = 1'b0;
      dir_op("post_rst", 0, 32'h1234_5678, 32'h1111_1111,
             0, 0, 32'h2345_6789, 0, 0);

      dir_op("k1", 1, 32'hFFFF_FFFF, 1, 0, 0, 0, 1, 0);
      dir_op("k1sub", 1, 5, 7, 1, 1, 32'hFFFF_FFFE, 0, 0);
      dir_op("w1", 2, 32'h0000_FFFF, 1, 0, 0, 0, 1, 0);
      dir_op("w1sub", 2, 5, 7, 1, 1, 32'h0000_FFFE, 0, 0);
      dir_op("k3", 3, 32'h7FF, 1, 0, 0, 32'h800, 0, 1);
      dir_op("k3wrap", 3, 32'hFFF, 32'hFFF, 1, 0,
             32'hFFF, 1, 0);

      for (int i = 0; i < 1000; i++) rand_op(0);
      for (int i = 0; i < 150; i++) rand_op(1);
      for (int i = 0; i < 150; i++) rand_op(2);
      for (int i = 0; i < 150; i++) rand_op(3);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
